instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/execute sequencer for the 8-bit micro. Fetches 9-bit instructions
//  from program memory over a req/ack handshake, presents each one to the control unit
//  for exactly one execute cycle, and owns the program counter (sequential or jump target).
//  Provides run/single-step control, a halt opcode, and a fetch-timeout fault.
// PARAMETERS
//  ADDR_W    8   program counter / memory address width
//  INSTR_W   9   instruction width
//  WAIT_MAX  15  max FETCH cycles without i_Mem_Ack before FAULT (counter width 4)
// PORTS
//  Clk           in   1        system clock, rising edge
//  Rst           in   1        asynchronous, active-low reset (0 = reset)
//  i_Run         in   1        free-run enable, level
//  i_Step        in   1        single-step request, one-cycle pulse; honoured only in IDLE
//  o_Mem_Req     out  1        program memory read request
//  o_Mem_Addr    out  ADDR_W   read address (= o_PC)
//  i_Mem_Ack     in   1        read data valid; sampled only while o_Mem_Req=1
//  i_Mem_Data    in   INSTR_W  instruction word, valid with i_Mem_Ack
//  o_Instruction out  INSTR_W  latched instruction to control unit
//  o_Exec        out  1        one-cycle execute strobe to control unit
//  o_Flag_En     out  1        flags-register capture enable (MATH opcode during EXEC)
//  i_Jump_Taken  in   1        jump decision from jump logic, sampled in EXEC
//  i_Jump_Addr   in   ADDR_W   jump target, sampled in EXEC
//  o_PC          out  ADDR_W   program counter
//  o_Halted      out  1        halt opcode executed (sticky)
//  o_Fault       out  1        fetch timeout (sticky)
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE, PC=0, o_Instruction=0, wait counter=0, all outputs 0.
//  States: IDLE, FETCH, EXEC, HALT, FAULT. Outputs decoded from registered state/regs.
//  IDLE : i_Run=1 or i_Step=1 -> FETCH. Else stay.
//  FETCH: o_Mem_Req=1, o_Mem_Addr=PC held stable. Wait counter +1 per cycle w/o ack.
//   - i_Mem_Ack=1 at posedge: o_Instruction<=i_Mem_Data, counter<=0, -> EXEC.
//   - counter==WAIT_MAX and no ack -> FAULT. Ack in same cycle as expiry: ack wins.
//   - i_Run falling during FETCH does not abort; fetch+exec complete.
//  EXEC : single cycle. o_Exec=1; o_Flag_En=1 iff o_Instruction[8:6]==3'b101.
//   - o_Instruction==9'h1FF (HALT): PC unchanged, o_Exec still 1, -> HALT.
//   - else PC<=i_Jump_Taken ? i_Jump_Addr : PC+1 (mod 2^ADDR_W, 8'hFF -> 8'h00);
//     -> FETCH if i_Run=1, else IDLE.
//  HALT : o_Halted=1; stays until reset. i_Run/i_Step ignored.
//  FAULT: o_Fault=1, o_Mem_Req=0; stays until reset.
//  i_Step outside IDLE ignored (not queued). i_Mem_Ack with o_Mem_Req=0 ignored.
//  Throughput: min 2 cycles/instruction (ack in first FETCH cycle).
//  Reset mid-FETCH drops request immediately (async); memory must tolerate abandoned req.
// TESTING
//  1 Reset, i_Run=1, mem acks in 1st cycle, words 0x001,0x002 -> o_Exec every 2nd cycle,
//    o_PC 0,1,2; o_Instruction 0x001 then 0x002.
//  2 i_Run=0, i_Step pulse, ack after 3 cycles -> exactly one o_Exec, PC 0->1, back in IDLE;
//    o_Mem_Addr stable at 0 all 4 FETCH cycles.
//  3 Fetch 9'h140 (MATH) -> o_Flag_En=1 with o_Exec; fetch 9'h040 -> o_Flag_En=0.
//  4 PC=0xFF, no jump -> PC=0x00; PC=0x10 with i_Jump_Taken=1, i_Jump_Addr=0x80 -> next
//    o_Mem_Addr=0x80.
//  5 No ack for 15 FETCH cycles -> o_Fault=1, o_Mem_Req=0, sticky; ack on 15th cycle
//    instead -> EXEC, no fault.
//  6 Fetch 9'h1FF -> o_Halted=1, PC unchanged, no further o_Mem_Req; Rst=0 mid-FETCH
//    -> o_Mem_Req=0 and PC=0 without a clock edge.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches instructions over a req/ack handshake, presents each
// for one execute cycle, and owns the program counter, halt state and fetch-timeout fault.
module instr_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 9,
    parameter int WAIT_MAX = 15
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               i_Run,
    input  logic               i_Step,
    output logic               o_Mem_Req,
    output logic [ADDR_W-1:0]  o_Mem_Addr,
    input  logic               i_Mem_Ack,
    input  logic [INSTR_W-1:0] i_Mem_Data,
    output logic [INSTR_W-1:0] o_Instruction,
    output logic               o_Exec,
    output logic               o_Flag_En,
    input  logic               i_Jump_Taken,
    input  logic [ADDR_W-1:0]  i_Jump_Addr,
    output logic [ADDR_W-1:0]  o_PC,
    output logic               o_Halted,
    output logic               o_Fault
);

    localparam int CNT_W = 4;
    localparam logic [INSTR_W-1:0] HALT_OP = '1;
    localparam logic [2:0]         MATH_OP = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               memReq_q, memReq_d;
    logic               exec_q, exec_d;
    logic               flagEn_q, flagEn_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_Run || i_Step) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            // The counter holds the number of ack-less cycles already spent, so the
            // WAIT_MAX-th consecutive cycle without an ack is the last one allowed.
            FETCH: begin
                if (i_Mem_Ack) begin
                    instr_d = i_Mem_Data;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                if (instr_q == HALT_OP) begin
                    state_d = HALT;
                end else begin
                    pc_d    = i_Jump_Taken ? i_Jump_Addr : pc_q + ADDR_W'(1);
                    state_d = i_Run ? FETCH : IDLE;
                end
            end
            default: begin
            end
        endcase

        memReq_d = (state_d == FETCH);
        exec_d   = (state_d == EXEC);
        flagEn_d = (state_d == EXEC) && (instr_d[INSTR_W-1 -: 3] == MATH_OP);
        halted_d = (state_d == HALT);
        fault_d  = (state_d == FAULT);
    end

    // Outputs are registered alongside the state so they change only on clock edges
    // (or immediately on reset).
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            cnt_q    <= '0;
            memReq_q <= 1'b0;
            exec_q   <= 1'b0;
            flagEn_q <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            memReq_q <= memReq_d;
            exec_q   <= exec_d;
            flagEn_q <= flagEn_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign o_Mem_Req     = memReq_q;
    assign o_Mem_Addr    = pc_q;
    assign o_PC          = pc_q;
    assign o_Instruction = instr_q;
    assign o_Exec        = exec_q;
    assign o_Flag_En     = flagEn_q;
    assign o_Halted      = halted_q;
    assign o_Fault       = fault_q;

endmodule
